// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, 1-cycle synchronous imem interface, IF/ID register
// with a 1-entry skid buffer, and branch redirect with flush/misalign/statistics.
module fetch_pc_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_req,
  input  logic [31:0]      imem_rdata,
  output logic [WIDTH-1:0] id_pc,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_v_q, pend_v_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]      skid_inst_q, skid_inst_d;
  logic             id_valid_q, id_valid_d;
  logic [WIDTH-1:0] id_pc_q, id_pc_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_s;

  assign req_s = ~stall & ~br_taken;

  // Next-state logic for PC, in-flight tracking, skid buffer and IF/ID register.
  always_comb begin
    pc_d        = pc_q;
    pend_v_d    = pend_v_q;
    pend_pc_d   = pend_pc_q;
    skid_v_d    = skid_v_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    flush_d     = 1'b0;
    misalign_d  = 1'b0;
    cnt_d       = cnt_q;
    if (br_taken) begin
      // Redirect wins over stall: drop every wrong-path word and restart at the aligned target.
      pc_d       = {br_target[WIDTH-1:2], 2'b00};
      pend_v_d   = 1'b0;
      skid_v_d   = 1'b0;
      id_valid_d = 1'b0;
      id_inst_d  = NOP;
      flush_d    = 1'b1;
      misalign_d = (br_target[1:0] != 2'b00);
      cnt_d      = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      if (req_s) begin
        pc_d      = pc_q + WIDTH'(4);
        pend_v_d  = 1'b1;
        pend_pc_d = pc_q;
      end else begin
        pend_v_d  = 1'b0;
      end
      if (stall) begin
        if (pend_v_q) begin
          skid_v_d    = 1'b1;
          skid_pc_d   = pend_pc_q;
          skid_inst_d = imem_rdata;
        end else begin
          skid_v_d    = skid_v_q;
        end
      end else if (skid_v_q) begin
        id_valid_d = 1'b1;
        id_pc_d    = skid_pc_q;
        id_inst_d  = skid_inst_q;
        skid_v_d   = 1'b0;
      end else if (pend_v_q) begin
        id_valid_d = 1'b1;
        id_pc_d    = pend_pc_q;
        id_inst_d  = imem_rdata;
      end else begin
        id_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset clears everything immediately, discarding any in-flight word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      pend_v_q    <= 1'b0;
      pend_pc_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= 32'h0000_0000;
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      id_inst_q   <= NOP;
      flush_q     <= 1'b0;
      misalign_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_v_q    <= pend_v_d;
      pend_pc_q   <= pend_pc_d;
      skid_v_q    <= skid_v_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      flush_q     <= flush_d;
      misalign_q  <= misalign_d;
      cnt_q       <= cnt_d;
    end
  end

  assign imem_addr    = pc_q;
  assign imem_req     = req_s;
  assign id_pc        = id_pc_q;
  assign id_inst      = id_inst_q;
  assign id_valid     = id_valid_q;
  assign flush        = flush_q;
  assign misalign     = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: expected ID/flush/PC state is queued per step and
// popped after the clock edge; the instruction memory returns its address as data.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        flush;
  logic        misalign;
  logic [15:0] redirect_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fl;
    logic        mis;
    logic [31:0] addr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
    .misalign(misalign), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous memory returning the fetch address as the instruction word
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic fl, input logic mis, input logic [31:0] addr,
                              input logic [15:0] cnt);
    exp_t e;
    e.v = v; e.pc = pc; e.inst = inst; e.fl = fl; e.mis = mis; e.addr = addr; e.cnt = cnt;
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, clock, then pop and compare.
  task automatic apply(input logic st, input logic br, input logic [31:0] tgt, input exp_t e);
    exp_t g;
    stall = st; br_taken = br; br_target = tgt;
    sb.push_back(e);
    #1;
    chk("imem_req", {31'h0, imem_req}, {31'h0, ~st & ~br});
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("id_valid", {31'h0, id_valid}, {31'h0, g.v});
    if (g.v) chk("id_pc", id_pc, g.pc);
    chk("id_inst", id_inst, g.inst);
    chk("flush", {31'h0, flush}, {31'h0, g.fl});
    chk("misalign", {31'h0, misalign}, {31'h0, g.mis});
    chk("imem_addr", imem_addr, g.addr);
    chk("redirect_cnt", {16'h0, redirect_cnt}, {16'h0, g.cnt});
  endtask

  task automatic chk_reset_vals();
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0000_0013);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_cnt", {16'h0, redirect_cnt}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    chk_reset_vals();
    reset = 1'b0;

    // Streaming fetch from RESET_PC
    apply(1'b0, 1'b0, 32'h0, mk(1'b0, 32'h0,  32'h13, 1'b0, 1'b0, 32'h4,  16'd0));
    apply(1'b0, 1'b0, 32'h0, mk(1'b1, 32'h0,  32'h0,  1'b0, 1'b0, 32'h8,  16'd0));
    apply(1'b0, 1'b0, 32'h0, mk(1'b1, 32'h4,  32'h4,  1'b0, 1'b0, 32'hC,  16'd0));
    // Stall 3 cycles with word 0x8 in flight
    apply(1'b1, 1'b0, 32'h0, mk(1'b1, 32'h4,  32'h4,  1'b0, 1'b0, 32'hC,  16'd0));
    apply(1'b1, 1'b0, 32'h0, mk(1'b1, 32'h4,  32'h4,  1'b0, 1'b0, 32'hC,  16'd0));
    apply(1'b1, 1'b0, 32'h0, mk(1'b1, 32'h4,  32'h4,  1'b0, 1'b0, 32'hC,  16'd0));
    apply(1'b0, 1'b0, 32'h0, mk(1'b1, 32'h8,  32'h8,  1'b0, 1'b0, 32'h10, 16'd0));
    apply(1'b0, 1'b0, 32'h0, mk(1'b1, 32'hC,  32'hC,  1'b0, 1'b0, 32'h14, 16'd0));
    // Redirect under stall to 0x100
    apply(1'b1, 1'b1, 32'h100, mk(1'b0, 32'h0, 32'h13, 1'b1, 1'b0, 32'h100, 16'd1));
    apply(1'b0, 1'b0, 32'h0,   mk(1'b0, 32'h0, 32'h13, 1'b0, 1'b0, 32'h104, 16'd1));
    apply(1'b0, 1'b0, 32'h0,   mk(1'b1, 32'h100, 32'h100, 1'b0, 1'b0, 32'h108, 16'd1));
    // Misaligned target 0x102 resumes at 0x100
    apply(1'b0, 1'b1, 32'h102, mk(1'b0, 32'h0, 32'h13, 1'b1, 1'b1, 32'h100, 16'd2));
    apply(1'b0, 1'b0, 32'h0,   mk(1'b0, 32'h0, 32'h13, 1'b0, 1'b0, 32'h104, 16'd2));
    apply(1'b0, 1'b0, 32'h0,   mk(1'b1, 32'h100, 32'h100, 1'b0, 1'b0, 32'h108, 16'd2));
    // Back-to-back redirects: 0x300 wins, 0x200 never reaches ID
    apply(1'b0, 1'b1, 32'h200, mk(1'b0, 32'h0, 32'h13, 1'b1, 1'b0, 32'h200, 16'd3));
    apply(1'b0, 1'b1, 32'h300, mk(1'b0, 32'h0, 32'h13, 1'b1, 1'b0, 32'h300, 16'd4));
    apply(1'b0, 1'b0, 32'h0,   mk(1'b0, 32'h0, 32'h13, 1'b0, 1'b0, 32'h304, 16'd4));
    apply(1'b0, 1'b0, 32'h0,   mk(1'b1, 32'h300, 32'h300, 1'b0, 1'b0, 32'h308, 16'd4));
    apply(1'b0, 1'b0, 32'h0,   mk(1'b1, 32'h304, 32'h304, 1'b0, 1'b0, 32'h30C, 16'd4));
    // Capture 0x308 into the skid, then reset mid-cycle
    apply(1'b1, 1'b0, 32'h0,   mk(1'b1, 32'h304, 32'h304, 1'b0, 1'b0, 32'h30C, 16'd4));
    reset = 1'b1;
    #1;
    chk_reset_vals();
    stall = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals();
    reset = 1'b0;
    apply(1'b0, 1'b0, 32'h0, mk(1'b0, 32'h0, 32'h13, 1'b0, 1'b0, 32'h4, 16'd0));
    apply(1'b0, 1'b0, 32'h0, mk(1'b1, 32'h0, 32'h0,  1'b0, 1'b0, 32'h8, 16'd0));
    apply(1'b0, 1'b0, 32'h0, mk(1'b1, 32'h4, 32'h4,  1'b0, 1'b0, 32'hC, 16'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
